mem_stage: RTL and testbench
============================

# mem_stage

Data-memory stage of the five-stage MIPS pipeline: sits between the EX→DM pipeline register and the DM→RW register. It turns a load or store from EX into a request/ready transaction on the data bus, with byte enables, load sign/zero extension and alignment checking. It stalls the upstream pipeline while the bus is busy and presents a registered write-back record to the RW stage.

## Interface
- TIMEOUT, 16: number of BUSY cycles without bus_ready before the access is aborted (must be ≥ 2).
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- in_valid  in  1  EX→DM slot holds a valid instruction.
- in_op  in  4  memory op: 0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9–15 are treated as NONE.
- in_addr  in  32  effective address, or the ALU result for NONE.
- in_sdata  in  32  store data, rt value.
- in_dst  in  5  destination GPR; 0 means no write.
- in_pc  in  32  instruction PC.
- stall  out  1  upstream must hold all in_* stable and freeze its pipeline registers.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  write strobe, registered.
- bus_addr  out  32  word address: {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  store data, replicated into lanes.
- bus_ready  in  1  completes the current request in this cycle.
- bus_rdata  in  32  read word, valid when bus_ready=1.
- out_valid  out  1  RW record valid.
- out_wen  out  1  GPR write enable.
- out_dst  out  5  GPR address.
- out_wdata  out  32  GPR write data.
- out_pc  out  32  PC of the retiring instruction.
- out_exc  out  2  0 none, 1 misaligned, 2 bus timeout.

## Operation
- States: IDLE and BUSY. Reset puts the block in IDLE, drives every output to 0 and clears the timeout counter.
- **IDLE, in_valid=1, op NONE:**
  - Pass through to the out_* registers on the next edge.
  - out_wdata=in_addr, out_wen=(in_dst≠0), out_exc=0.
  - No stall.
- **IDLE, load/store, misaligned:**
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No bus access and no stall.
  - Next edge: out_valid=1, out_wen=0, out_exc=1.
- **IDLE, load/store, aligned:**
  - stall=1 combinationally.
  - Next edge: latch op, addr, dst, pc and byte lane; drive bus_req=1, bus_we=store, bus_be and bus_wdata; enter BUSY.
- **Byte enables:**
  - Word: 4'b1111.
  - Halfword: 4'b0011 when addr[1]=0, 4'b1100 when addr[1]=1.
  - Byte: 4'b0001 << addr[1:0].
- **Store data:** SW sends sdata; SH sends {2{sdata[15:0]}}; SB sends {4{sdata[7:0]}}.
- **BUSY:**
  - bus_req stays 1 and all bus_* outputs stay stable until bus_ready.
  - stall = ~bus_ready.
- **bus_ready=1 in BUSY:**
  - Next edge: bus_req=0, state returns to IDLE, out_valid=1.
  - Loads: out_wen=(dst≠0), out_wdata = extracted lane, extended.
  - Extraction: LB/LBU select byte addr[1:0], LH/LHU select half addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - Stores: out_wen=0.
- **Timeout:**
  - The counter increments each BUSY cycle with bus_ready=0.
  - On reaching TIMEOUT-1 with bus_ready=0: abort. Next edge: bus_req=0, state IDLE, out_valid=1, out_wen=0, out_exc=2. stall drops in the abort cycle.
  - bus_ready arriving in the same cycle as the limit wins: the access completes normally.
- **Default output:** out_valid=0 on any edge where no record retires (IDLE with in_valid=0, or BUSY without ready or abort). All other out_* fields hold their last values.
- **Reset mid-BUSY:** bus_req drops to 0 immediately (asynchronously); the transaction is abandoned and no record retires.

## Timing
- Pass-through (NONE or misaligned): 1-cycle latency, no stall.
- Memory access: accept at cycle 0, bus_req at cycle 1, bus_ready at cycle 1+k, out_valid at cycle 2+k.
- Minimum access is 2 cycles, with stall high for cycles 0..k.
- Upstream presents the next instruction on the cycle stall falls; that instruction is evaluated in IDLE on the following cycle.
- out_valid is a single-cycle pulse per retired instruction.

## Test plan
- **ADD pass-through:** in_op=0, in_addr=0x0000_1234, dst=8 → next cycle out_valid=1, out_wen=1, out_wdata=0x1234; stall never asserts.
- **LB sign extension:** addr=0x0000_0103, rdata=0x80FF_7F01 (lane 3 = 0x80), ready after 3 cycles → bus_be=4'b1000, stall high for 4 cycles, out_wdata=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- **SH upper half:** addr=0x0000_0202, sdata=0x1234_ABCD → bus_we=1, bus_be=4'b1100, bus_wdata=0xABCD_ABCD, bus_addr=0x200, out_wen=0.
- **Misaligned LW:** addr=0x0000_0006 → bus_req stays 0, out_exc=1 one cycle later, out_wen=0.
- **Timeout:** TIMEOUT=4, bus_ready held 0 → abort at the 4th BUSY cycle, out_exc=2, bus_req=0.
- **Ready at the limit:** bus_ready at the 4th BUSY cycle → normal completion with out_exc=0.
- **Reset mid-BUSY:** assert reset=0 while bus_req=1 → bus_req and all outputs read 0 before the next clock edge; after release, state is IDLE and no stale out_valid pulse appears.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: data-memory stage of the MIPS pipeline. Converts EX loads and
// stores into a request/ready bus transaction with byte enables, performs
// alignment checks and load extension, stalls upstream while the bus is
// busy, and presents a registered write-back record to the RW stage.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_sdata,
  input  logic [4:0]  in_dst,
  input  logic [31:0] in_pc,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        out_valid,
  output logic        out_wen,
  output logic [4:0]  out_dst,
  output logic [31:0] out_wdata,
  output logic [31:0] out_pc,
  output logic [1:0]  out_exc
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ALIGN   = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  // Load or store (ops 9..15 behave like NONE)
  function automatic logic is_mem(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_SB);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return a != 2'b00;
      OP_LH, OP_LHU, OP_SH: return a[0];
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         return 4'b1111;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b1100 : 4'b0011;
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << a;
      default:              return 4'b0000;
    endcase
  endfunction

  // Store data replicated into every lane the access could hit
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] sd);
    case (op)
      OP_SW:   return sd;
      OP_SH:   return {2{sd[15:0]}};
      OP_SB:   return {4{sd[7:0]}};
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input logic [3:0] op, input logic [1:0] a,
                                            input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h00_0000, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      default: return rd;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic [4:0]      dst_q, dst_d;
  logic [31:0]     pc_q, pc_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic            out_valid_q, out_valid_d;
  logic            out_wen_q, out_wen_d;
  logic [4:0]      out_dst_q, out_dst_d;
  logic [31:0]     out_wdata_q, out_wdata_d;
  logic [31:0]     out_pc_q, out_pc_d;
  logic [1:0]      out_exc_q, out_exc_d;

  logic            mem_op_s;
  logic            misal_s;
  logic            accept_s;
  logic            abort_s;

  assign mem_op_s = is_mem(in_op);
  assign misal_s  = misaligned(in_op, in_addr[1:0]);
  assign accept_s = (state_q == ST_IDLE) && in_valid && mem_op_s && !misal_s;
  assign abort_s  = (state_q == ST_BUSY) && !bus_ready && (cnt_q == CNT_LIMIT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept an aligned access, leave BUSY on ready or abort
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_BUSY;
        else          state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (bus_ready || abort_s) state_d = ST_IDLE;
        else                      state_d = ST_BUSY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall output: held on acceptance and while waiting, released on ready/abort
  always_comb begin
    stall = 1'b0;
    case (state_q)
      ST_IDLE: stall = accept_s;
      ST_BUSY: stall = !bus_ready && !abort_s;
      default: stall = 1'b0;
    endcase
  end

  // Datapath next values: latch requests, retire records, run the timeout counter
  always_comb begin
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    dst_d       = dst_q;
    pc_d        = pc_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    out_valid_d = 1'b0;
    out_wen_d   = out_wen_q;
    out_dst_d   = out_dst_q;
    out_wdata_d = out_wdata_q;
    out_pc_d    = out_pc_q;
    out_exc_d   = out_exc_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!in_valid) begin
          out_valid_d = 1'b0;
        end else if (!mem_op_s) begin
          out_valid_d = 1'b1;
          out_wen_d   = (in_dst != 5'd0);
          out_dst_d   = in_dst;
          out_wdata_d = in_addr;
          out_pc_d    = in_pc;
          out_exc_d   = EXC_NONE;
        end else if (misal_s) begin
          out_valid_d = 1'b1;
          out_wen_d   = 1'b0;
          out_dst_d   = in_dst;
          out_wdata_d = in_addr;
          out_pc_d    = in_pc;
          out_exc_d   = EXC_ALIGN;
        end else begin
          op_d        = in_op;
          addr_d      = in_addr;
          dst_d       = in_dst;
          pc_d        = in_pc;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store(in_op);
          bus_addr_d  = {in_addr[31:2], 2'b00};
          bus_be_d    = byte_en(in_op, in_addr[1:0]);
          bus_wdata_d = store_data(in_op, in_sdata);
        end
      end
      ST_BUSY: begin
        if (bus_ready) begin
          cnt_d       = '0;
          bus_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_dst_d   = dst_q;
          out_pc_d    = pc_q;
          out_exc_d   = EXC_NONE;
          if (is_store(op_q)) begin
            out_wen_d   = 1'b0;
            out_wdata_d = addr_q;
          end else begin
            out_wen_d   = (dst_q != 5'd0);
            out_wdata_d = load_data(op_q, addr_q[1:0], bus_rdata);
          end
        end else if (abort_s) begin
          cnt_d       = '0;
          bus_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_wen_d   = 1'b0;
          out_dst_d   = dst_q;
          out_wdata_d = addr_q;
          out_pc_d    = pc_q;
          out_exc_d   = EXC_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d     = '0;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears everything including bus_req
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      op_q        <= 4'd0;
      addr_q      <= 32'h0000_0000;
      dst_q       <= 5'd0;
      pc_q        <= 32'h0000_0000;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      out_valid_q <= 1'b0;
      out_wen_q   <= 1'b0;
      out_dst_q   <= 5'd0;
      out_wdata_q <= 32'h0000_0000;
      out_pc_q    <= 32'h0000_0000;
      out_exc_q   <= 2'd0;
    end else begin
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      dst_q       <= dst_d;
      pc_q        <= pc_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      out_valid_q <= out_valid_d;
      out_wen_q   <= out_wen_d;
      out_dst_q   <= out_dst_d;
      out_wdata_q <= out_wdata_d;
      out_pc_q    <= out_pc_d;
      out_exc_q   <= out_exc_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign out_valid = out_valid_q;
  assign out_wen   = out_wen_q;
  assign out_dst   = out_dst_q;
  assign out_wdata = out_wdata_q;
  assign out_pc    = out_pc_q;
  assign out_exc   = out_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table plus randomized instructions for mem_stage,
// with expected results computed from the memory-stage rules in plain
// arithmetic; hand-written sequences cover reset and reset mid-access.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_sdata;
  logic [4:0]  in_dst;
  logic [31:0] in_pc;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        out_valid;
  logic        out_wen;
  logic [4:0]  out_dst;
  logic [31:0] out_wdata;
  logic [31:0] out_pc;
  logic [1:0]  out_exc;

  int errors = 0;
  int checks = 0;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr), .in_sdata(in_sdata),
    .in_dst(in_dst), .in_pc(in_pc), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .out_valid(out_valid), .out_wen(out_wen), .out_dst(out_dst),
    .out_wdata(out_wdata), .out_pc(out_pc), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  dst;
    logic [31:0] pc;
    int          k;        // BUSY cycle index at which ready arrives (>=TIMEOUT: never)
    logic [31:0] rdata;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_exc;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    logic        chk_wd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd6:       return 4;
      4'd2, 4'd3, 4'd7: return 2;
      4'd4, 4'd5, 4'd8: return 1;
      default:          return 0;
    endcase
  endfunction

  function automatic logic ref_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic ref_misal(input logic [3:0] op, input logic [31:0] a);
    int sz;
    sz = ref_size(op);
    if (sz == 0) return 1'b0;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      4'd2:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
      4'd3:    return h;
      4'd4:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
      4'd5:    return b;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] a);
    int sz;
    sz = ref_size(op);
    if (sz == 4) return 4'hF;
    if (sz == 2) return 4'((32'd3) << (a % 4));
    return 4'((32'd1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_bwdata(input logic [3:0] op, input logic [31:0] sd);
    if (op == 4'd7) return (sd & 32'hFFFF) * 32'h0001_0001;
    if (op == 4'd8) return (sd & 32'hFF) * 32'h0101_0101;
    return sd;
  endfunction

  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [4:0] dst,
                                 input logic [31:0] pc, input int k, input logic [31:0] rdata);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.dst = dst; v.pc = pc; v.k = k; v.rdata = rdata;
    v.exp_be = ref_be(op, addr);
    v.exp_bwdata = ref_bwdata(op, sdata);
    v.exp_wdata = 32'h0;
    v.chk_wd = 1'b0;
    if (ref_size(op) == 0) begin
      v.exp_wen = (dst != 5'd0); v.exp_wdata = addr; v.exp_exc = 2'd0; v.chk_wd = 1'b1;
    end else if (ref_misal(op, addr)) begin
      v.exp_wen = 1'b0; v.exp_exc = 2'd1;
    end else if (k >= TIMEOUT) begin
      v.exp_wen = 1'b0; v.exp_exc = 2'd2;
    end else if (ref_store(op)) begin
      v.exp_wen = 1'b0; v.exp_exc = 2'd0;
    end else begin
      v.exp_wen = (dst != 5'd0); v.exp_exc = 2'd0;
      v.exp_wdata = ref_load(op, addr, rdata); v.chk_wd = 1'b1;
    end
    return v;
  endfunction

  // Apply one instruction, act as bus slave, check stall/bus/record
  task automatic run_vec(input vec_t v);
    logic acc;
    int   lim;
    int   nstall;
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_op = v.op; in_addr = v.addr; in_sdata = v.sdata;
    in_dst = v.dst; in_pc = v.pc; bus_ready = 1'b0;
    acc = (ref_size(v.op) != 0) && !ref_misal(v.op, v.addr);
    #1;
    chk("stall_accept", 32'(stall), 32'(acc));
    nstall = stall ? 1 : 0;
    if (!acc) begin
      @(negedge clk);
      in_valid = 1'b0;
      chk("bus_req_idle", 32'(bus_req), 32'd0);
    end else begin
      lim = (v.k < TIMEOUT) ? v.k : TIMEOUT - 1;
      for (int j = 0; j <= lim; j++) begin
        @(negedge clk);
        chk("bus_req", 32'(bus_req), 32'd1);
        chk("bus_we", 32'(bus_we), 32'(ref_store(v.op)));
        chk("bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
        chk("bus_be", 32'(bus_be), 32'(v.exp_be));
        if (ref_store(v.op)) chk("bus_wdata", bus_wdata, v.exp_bwdata);
        chk("busy_out_valid", 32'(out_valid), 32'd0);
        if (j == v.k) begin
          bus_ready = 1'b1;
          bus_rdata = v.rdata;
        end
        #1;
        if (stall) nstall++;
        chk("stall_busy", 32'(stall), 32'(j != lim));
      end
      @(negedge clk);
      bus_ready = 1'b0; in_valid = 1'b0; bus_rdata = $urandom;
      chk("bus_req_done", 32'(bus_req), 32'd0);
      chk("stall_cycles", 32'(nstall), 32'(lim + 1));
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_wen", 32'(out_wen), 32'(v.exp_wen));
    chk("out_exc", 32'(out_exc), 32'(v.exp_exc));
    chk("out_pc", out_pc, v.pc);
    chk("out_dst", 32'(out_dst), 32'(v.dst));
    if (v.chk_wd) chk("out_wdata", out_wdata, v.exp_wdata);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [4:0] dst,
                              input logic [31:0] pc, input int k, input logic [31:0] rdata,
                              input logic wen, input logic [31:0] wdata, input logic [1:0] exc,
                              input logic [3:0] be, input logic [31:0] bwdata, input logic cwd);
    vec_t v;
    v.op = op; v.addr = addr; v.sdata = sdata; v.dst = dst; v.pc = pc; v.k = k;
    v.rdata = rdata; v.exp_wen = wen; v.exp_wdata = wdata; v.exp_exc = exc;
    v.exp_be = be; v.exp_bwdata = bwdata; v.chk_wd = cwd;
    return v;
  endfunction

  vec_t tbl[16];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // op, addr, sdata, dst, pc, k, rdata, wen, wdata, exc, be, bwdata, chk_wd
    tbl[0]  = mk(4'd0,  32'h0000_1234, 32'h0, 5'd8,  32'h100, 0, 32'h0,         1'b1, 32'h0000_1234, 2'd0, 4'h0, 32'h0, 1'b1);
    tbl[1]  = mk(4'd4,  32'h0000_0103, 32'h0, 5'd9,  32'h104, 3, 32'h80FF_7F01, 1'b1, 32'hFFFF_FF80, 2'd0, 4'b1000, 32'h0, 1'b1);
    tbl[2]  = mk(4'd5,  32'h0000_0103, 32'h0, 5'd10, 32'h108, 3, 32'h80FF_7F01, 1'b1, 32'h0000_0080, 2'd0, 4'b1000, 32'h0, 1'b1);
    tbl[3]  = mk(4'd7,  32'h0000_0202, 32'h1234_ABCD, 5'd0, 32'h10C, 0, 32'h0,  1'b0, 32'h0, 2'd0, 4'b1100, 32'hABCD_ABCD, 1'b0);
    tbl[4]  = mk(4'd1,  32'h0000_0006, 32'h0, 5'd5,  32'h110, 0, 32'h0,         1'b0, 32'h0, 2'd1, 4'hF, 32'h0, 1'b0);
    tbl[5]  = mk(4'd1,  32'h0000_0040, 32'h0, 5'd6,  32'h114, 9, 32'h0,         1'b0, 32'h0, 2'd2, 4'hF, 32'h0, 1'b0);
    tbl[6]  = mk(4'd1,  32'h0000_0044, 32'h0, 5'd7,  32'h118, 3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 2'd0, 4'hF, 32'h0, 1'b1);
    tbl[7]  = mk(4'd2,  32'h0000_0010, 32'h0, 5'd11, 32'h11C, 1, 32'h1234_8765, 1'b1, 32'hFFFF_8765, 2'd0, 4'b0011, 32'h0, 1'b1);
    tbl[8]  = mk(4'd3,  32'h0000_0012, 32'h0, 5'd12, 32'h120, 0, 32'h8765_1234, 1'b1, 32'h0000_8765, 2'd0, 4'b1100, 32'h0, 1'b1);
    tbl[9]  = mk(4'd8,  32'h0000_0301, 32'h0000_00AB, 5'd1, 32'h124, 2, 32'h0,  1'b0, 32'h0, 2'd0, 4'b0010, 32'hABAB_ABAB, 1'b0);
    tbl[10] = mk(4'd6,  32'h0000_0400, 32'hCAFE_F00D, 5'd2, 32'h128, 0, 32'h0,  1'b0, 32'h0, 2'd0, 4'hF, 32'hCAFE_F00D, 1'b0);
    tbl[11] = mk(4'd4,  32'h0000_0500, 32'h0, 5'd0,  32'h12C, 0, 32'h0000_007F, 1'b0, 32'h0000_007F, 2'd0, 4'b0001, 32'h0, 1'b1);
    tbl[12] = mk(4'd12, 32'h0000_0055, 32'h0, 5'd3,  32'h130, 0, 32'h0,         1'b1, 32'h0000_0055, 2'd0, 4'h0, 32'h0, 1'b1);
    tbl[13] = mk(4'd7,  32'h0000_0007, 32'h0, 5'd4,  32'h134, 0, 32'h0,         1'b0, 32'h0, 2'd1, 4'h0, 32'h0, 1'b0);
    tbl[14] = mk(4'd0,  32'h0000_0ABC, 32'h0, 5'd0,  32'h138, 0, 32'h0,         1'b0, 32'h0000_0ABC, 2'd0, 4'h0, 32'h0, 1'b1);
    tbl[15] = mk(4'd4,  32'h0000_0602, 32'h0, 5'd13, 32'h13C, 1, 32'h007F_0000, 1'b1, 32'h0000_007F, 2'd0, 4'b0100, 32'h0, 1'b1);

    reset = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_addr = 32'h0; in_sdata = 32'h0;
    in_dst = 5'd0; in_pc = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Reset while an access is outstanding
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd1; in_addr = 32'h0000_0800; in_dst = 5'd1; in_pc = 32'h200;
    @(negedge clk);
    chk("mid_bus_req_before", 32'(bus_req), 32'd1);
    #2;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_bus_req", 32'(bus_req), 32'd0);
    chk("mid_bus_addr", bus_addr, 32'h0);
    chk("mid_bus_be", 32'(bus_be), 32'd0);
    chk("mid_out_pc", out_pc, 32'h0);
    chk("mid_out_wdata", out_wdata, 32'h0);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_bus_req", 32'(bus_req), 32'd0);
    end
    run_vec(tbl[6]);

    // Randomized instructions against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      rv = model(4'($urandom_range(0, 15)), a, $urandom, 5'($urandom_range(0, 31)),
                 $urandom, $urandom_range(0, 5), $urandom);
      run_vec(rv);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
